// File: rtl/nar_pkg.sv
// Shared types and helpers for the neuron accumulate/requantise blocks.
// Holds default formats, accumulator sizing and the sequencer states.
package nar_pkg;

   localparam int N_DEF = 10;
   localparam int Q_DEF = 8;

   // Full-precision accumulator width: product width plus growth for
   // ni products and one bias term.
   function automatic int acc_w(input int n, input int ni);
      return 2 * n + $clog2(ni + 1);
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LAST  = 2'd2,
      OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/nar_requant.sv
// Requantise a full-precision accumulator to N-bit Q-fraction format.
// Arithmetic shift, optional ReLU, then saturation to the N-bit range.
module nar_requant
   import nar_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int Q     = Q_DEF,
   parameter int ACC_W = acc_w(N_DEF, 16),
   parameter int ACT   = 1
) (
   input  logic [ACC_W-1:0] acc,
   output logic [N-1:0]     y
);

   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (N - 1)) - 1);
   localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

   logic signed [ACC_W-1:0] r;

   // Shift down with floor rounding, clamp negatives for ReLU, saturate.
   always_comb begin
      r = $signed(acc) >>> Q;
      if (ACT != 0 && r[ACC_W-1]) begin
         r = '0;
      end
      if (r > MAXV) begin
         y = MAXV[N-1:0];
      end else if (r < MINV) begin
         y = MINV[N-1:0];
      end else begin
         y = r[N-1:0];
      end
   end

endmodule

// File: rtl/neuron_mac.sv
// Weight/activation sequencer with full-precision multiply-accumulate.
// Walks one neuron's weights and bias, then emits a requantised result.
module neuron_mac
   import nar_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int Q          = Q_DEF,
   parameter int NUM_INPUTS = 16,
   parameter int ACT        = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [7:0]   layer_base,
   output logic [7:0]   rom_addr,
   input  logic [N-1:0] rom_data,
   output logic [7:0]   x_idx,
   input  logic [N-1:0] x_data,
   output logic [N-1:0] y,
   output logic         y_valid,
   output logic         busy
);

   localparam int ACC_W = acc_w(N, NUM_INPUTS);
   localparam logic [7:0] NI_W = 8'(NUM_INPUTS);

   state_t state_q, state_d;

   logic [7:0]              base_q;
   logic [7:0]              cnt_q;
   logic [7:0]              cnt_nx;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [2*N-1:0]   prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] bias_ext;
   logic [N-1:0]            y_r;

   logic accept;
   logic do_prod;
   logic do_bias;
   logic do_out;

   assign cnt_nx = cnt_q + 8'd1;

   // Signed product of returned data and the bias aligned to Q2Q.
   always_comb begin
      prod     = $signed(x_data) * $signed(rom_data);
      prod_ext = {{(ACC_W - 2 * N){prod[2*N-1]}}, prod};
      bias_ext = {{(ACC_W - N - Q){rom_data[N-1]}}, rom_data, {Q{1'b0}}};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-edge datapath controls.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      do_prod = 1'b0;
      do_bias = 1'b0;
      do_out  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            do_prod = 1'b1;
            if (cnt_nx == NI_W) begin
               state_d = LAST;
            end
         end
         LAST: begin
            do_bias = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            do_out = 1'b1;
            if (start) begin
               accept  = 1'b1;
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Address issue, accumulation and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         rom_addr <= '0;
         x_idx    <= '0;
         y        <= '0;
         y_valid  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         y_valid <= do_out;
         if (do_out) begin
            y    <= y_r;
            busy <= 1'b0;
         end
         if (do_prod) begin
            acc_q    <= acc_q + prod_ext;
            cnt_q    <= cnt_nx;
            rom_addr <= base_q + cnt_nx;
            if (cnt_nx != NI_W) begin
               x_idx <= cnt_nx;
            end
         end
         if (do_bias) begin
            acc_q <= acc_q + bias_ext;
         end
         if (accept) begin
            base_q   <= layer_base;
            cnt_q    <= '0;
            acc_q    <= '0;
            rom_addr <= layer_base;
            x_idx    <= '0;
            busy     <= 1'b1;
         end
      end
   end

   nar_requant #(
      .N     (N),
      .Q     (Q),
      .ACC_W (ACC_W),
      .ACT   (ACT)
   ) u_requant (
      .acc (acc_q),
      .y   (y_r)
   );

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with four inputs per neuron.
// Runs a ReLU instance and an identity instance side by side.
module tb_neuron_mac;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] layer_base = '0;

   logic [7:0] ra1, xi1, ra0, xi0;
   logic [9:0] rd1, xd1, rd0, xd0;
   logic [9:0] y1, y0;
   logic       yv1, yv0, b1, b0;

   logic [9:0] rom_mem [256];
   logic [9:0] x_mem   [256];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   neuron_mac #(.N(10), .Q(8), .NUM_INPUTS(4), .ACT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .layer_base(layer_base),
      .rom_addr(ra1), .rom_data(rd1), .x_idx(xi1), .x_data(xd1),
      .y(y1), .y_valid(yv1), .busy(b1)
   );

   neuron_mac #(.N(10), .Q(8), .NUM_INPUTS(4), .ACT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .layer_base(layer_base),
      .rom_addr(ra0), .rom_data(rd0), .x_idx(xi0), .x_data(xd0),
      .y(y0), .y_valid(yv0), .busy(b0)
   );

   // ROM and activation buffer register on the falling edge
   always @(negedge clk) begin
      rd1 <= rom_mem[ra1];
      xd1 <= x_mem[xi1];
      rd0 <= rom_mem[ra0];
      xd0 <= x_mem[xi0];
   end

   task automatic load(input logic [7:0] base, input int w, input int bias,
                       input int xv);
      logic [7:0] a;
      for (int i = 0; i < 4; i++) begin
         a = base + 8'(i);
         rom_mem[a] = 10'(w);
         x_mem[i] = 10'(xv);
      end
      a = base + 8'd4;
      rom_mem[a] = 10'(bias);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({ra1, xi1, y1, yv1, b1, ra0, xi0, y0, yv0, b0} !== 56'h0) begin
         n_fail++;
         $display("FAIL reset: got %h want 0",
                  {ra1, xi1, y1, yv1, b1, ra0, xi0, y0, yv0, b0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if ({yv1, b1, yv0, b0} !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_release: got %b want 0000", {yv1, b1, yv0, b0});
      end
   endtask

   task automatic run_op(input string nm, input logic [7:0] base, input int w,
                         input int bias, input int xv, input int e1,
                         input int e0);
      load(base, w, bias, xv);
      @(negedge clk);
      layer_base = base;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_chk++;
      if ({b1, b0} !== 2'b11) begin
         n_fail++;
         $display("FAIL %s busy_E0: got %b want 11", nm, {b1, b0});
      end
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if (yv1 !== (k == 6) || yv0 !== (k == 6)) begin
            n_fail++;
            $display("FAIL %s y_valid E%0d: got %b%b want %b", nm, k, yv1,
                     yv0, (k == 6));
         end
         n_chk++;
         if (b1 !== (k < 6) || b0 !== (k < 6)) begin
            n_fail++;
            $display("FAIL %s busy E%0d: got %b%b want %b", nm, k, b1, b0,
                     (k < 6));
         end
         if (k == 6) begin
            n_chk++;
            if (y1 !== 10'(e1)) begin
               n_fail++;
               $display("FAIL %s y_relu: got %0d want %0d", nm, $signed(y1),
                        e1);
            end
            n_chk++;
            if (y0 !== 10'(e0)) begin
               n_fail++;
               $display("FAIL %s y_ident: got %0d want %0d", nm, $signed(y0),
                        e0);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] ea;
      logic [7:0] ex;
      load(8'd254, 64, 0, 256);
      @(negedge clk);
      layer_base = 8'd254;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (k <= 4) begin
            ea = 8'd254 + 8'(k);
            ex = (k < 4) ? 8'(k) : 8'd3;
            n_chk++;
            if (ra1 !== ea || ra0 !== ea) begin
               n_fail++;
               $display("FAIL wrap rom_addr E%0d: got %0d want %0d", k, ra1,
                        ea);
            end
            n_chk++;
            if (xi1 !== ex || xi0 !== ex) begin
               n_fail++;
               $display("FAIL wrap x_idx E%0d: got %0d want %0d", k, xi1, ex);
            end
         end
         if (k == 6) begin
            n_chk++;
            if (yv1 !== 1'b1 || y1 !== 10'd256) begin
               n_fail++;
               $display("FAIL wrap y: got %0d v%b want 256 v1", y1, yv1);
            end
         end
      end
      @(posedge clk);
   endtask

   task automatic test_back_to_back();
      load(8'd0, 64, 128, 256);
      @(negedge clk);
      layer_base = 8'd0;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if (yv1 !== (k == 6 || k == 12) || yv0 !== (k == 6 || k == 12)) begin
            n_fail++;
            $display("FAIL b2b y_valid E%0d: got %b%b", k, yv1, yv0);
         end
         n_chk++;
         if (b1 !== (k < 12) || b0 !== (k < 12)) begin
            n_fail++;
            $display("FAIL b2b busy E%0d: got %b%b want %b", k, b1, b0,
                     (k < 12));
         end
         if (k == 6 || k == 12) begin
            n_chk++;
            if (y1 !== 10'd384 || y0 !== 10'd384) begin
               n_fail++;
               $display("FAIL b2b y E%0d: got %0d %0d want 384", k, y1, y0);
            end
         end
         if (k == 8) start = 1'b0;
      end
   endtask

   task automatic test_busy_ignore();
      load(8'd0, 128, 0, 256);
      @(negedge clk);
      layer_base = 8'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if (yv1 !== (k == 6) || b1 !== (k < 6)) begin
            n_fail++;
            $display("FAIL ignore E%0d: got v%b b%b want v%b b%b", k, yv1, b1,
                     (k == 6), (k < 6));
         end
         if (k == 6) begin
            n_chk++;
            if (y1 !== 10'd511 || y0 !== 10'd511) begin
               n_fail++;
               $display("FAIL ignore y: got %0d %0d want 511", y1, y0);
            end
         end
         if (k == 2 || k == 4) start = 1'b1;
         if (k == 3 || k == 5) start = 1'b0;
      end
   endtask

   task automatic test_abort();
      load(8'd0, 64, 0, 256);
      @(negedge clk);
      layer_base = 8'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({ra1, xi1, y1, yv1, b1, ra0, xi0, y0, yv0, b0} !== 56'h0) begin
         n_fail++;
         $display("FAIL abort_async: got %h want 0",
                  {ra1, xi1, y1, yv1, b1, ra0, xi0, y0, yv0, b0});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if (yv1 !== 1'b0 || yv0 !== 1'b0 || b1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet %0d: got v%b%b b%b want 0", k, yv1,
                     yv0, b1);
         end
      end
      run_op("after_abort", 8'd0, 64, 0, 256, 256, 256);
   endtask

   initial begin
      test_reset();
      run_op("unity", 8'd0, 64, 0, 256, 256, 256);
      run_op("bias", 8'd10, 64, 128, 256, 384, 384);
      run_op("sat_pos", 8'd20, 128, 0, 256, 511, 511);
      run_op("negative", 8'd30, -64, 0, 256, 0, -256);
      run_op("sat_neg", 8'd40, -128, -128, 256, 0, -512);
      run_op("floor", 8'd50, -1, 0, 1, 0, -1);
      test_wrap();
      test_back_to_back();
      test_busy_ignore();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk,
               n_fail);
      $finish;
   end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequencer and multiply-accumulate stage directly downstream of the weight ROM. On `start` it walks one neuron's weights and bias out of the ROM, fetches the matching input activations, and accumulates the products in full precision. It then requantises the sum to the N-bit, Q-fraction fixed-point format. The result leaves through a one-cycle valid pulse toward the next layer's activation buffer.

## Interface
- `N`, 10, data width of weights, activations and result (signed, two's complement)
- `Q`, 8, fractional bits of all N-bit values
- `NUM_INPUTS`, 16, inputs per neuron (1..255)
- `ACT`, 1, activation: 0 = identity with saturation, 1 = ReLU with saturation

- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: request one dot product; sampled only in IDLE
- `layer_base` in 8: ROM address of weight 0; latched on accepted `start`
- `rom_addr` out 8: registered address to the weight ROM
- `rom_data` in N: weight ROM data; valid one cycle after `rom_addr` (ROM registers on falling edge)
- `x_idx` out 8: registered index into the activation buffer; same one-cycle read latency
- `x_data` in N: activation for `x_idx`
- `y` out N: requantised result; holds until the next result
- `y_valid` out 1: one-cycle pulse when `y` updates
- `busy` out 1: high from the accepted `start` until the end of the last accumulate

## Operation
- FSM states:
  - IDLE: on `start`, latch `layer_base`, clear the accumulator and index, go to FETCH. `start` is ignored in all other states.
  - FETCH: the issue index runs i = 0..NUM_INPUTS.
    - For i < NUM_INPUTS: `rom_addr` = base+i and `x_idx` = i.
    - For i = NUM_INPUTS: `rom_addr` = base+NUM_INPUTS, which is the bias word; `x_idx` holds its last value.
    - After issuing i = NUM_INPUTS, go to LAST.
  - LAST: accumulate the final (bias) data, then go to OUT.
  - OUT: register `y`, pulse `y_valid`, return to IDLE.
- Accumulate rules:
  - Data returned for index i < NUM_INPUTS: acc += x_data * rom_data, a signed 2N-bit product in Q2Q format.
  - Bias word: acc += sign_extend(rom_data) << Q.
- `ACC_W` = 2N + clog2(NUM_INPUTS+1). The accumulator never overflows.
- Requantise:
  - r = acc >>> Q (arithmetic shift, truncation toward −∞).
  - If ACT = 1 and r < 0, r = 0.
  - Saturate r to [−2^(N−1), 2^(N−1)−1].
- Addresses wrap modulo 256: base+i is computed in 8 bits.

## Timing
- Reset values: `rom_addr` = 0, `x_idx` = 0, `y` = 0, `y_valid` = 0, `busy` = 0, state IDLE, accumulator 0.
- Edge numbering:
  - Accepted `start` at rising edge E0.
  - Address i is presented during cycle i+1 and its data is accumulated at E(i+1).
  - The bias is accumulated at E(NUM_INPUTS+1).
  - `y` and `y_valid` are updated at E(NUM_INPUTS+2).
- Latency from `start` to `y_valid` is NUM_INPUTS+2 edges; with NUM_INPUTS = 16, `y_valid` rises at E18.
- `busy` rises at E0 and falls at E(NUM_INPUTS+2), in the same edge that `y_valid` rises.
- `start` asserted during the `y_valid` cycle is accepted; back-to-back throughput is one result per NUM_INPUTS+2 cycles.
- `rst_n` asserted mid-operation:
  - The operation aborts immediately and all outputs return to reset values.
  - No `y_valid` is produced for the aborted operation.
  - The first `start` after reset release behaves normally.

## Structure
- Shared package `nar_pkg`: default N/Q, the `ACC_W` width function, and the FSM state enum (IDLE, FETCH, LAST, OUT).
- One sub-module, `nar_requant`, which is combinational and performs the shift, ReLU and saturation. It is parameterised by N, Q, ACC_W and ACT and is reused by later layers.
- The ROM and activation buffer are external to this block.

## Test plan
All cases use N = 10, Q = 8, NUM_INPUTS = 4, ACT = 1, and a ROM model that registers on the falling edge, unless stated otherwise.
- x = 256 for all inputs, weights = 64, bias = 0 -> `y` = 256, `y_valid` exactly at E6, `busy` high E0..E6.
- Same as above with bias = 128 -> `y` = 384. With weights = 128 and bias = 0 (sum 512) -> `y` = 511 (saturated).
- Weights = −64, x = 256, bias = 0 -> `y` = 0 with ACT = 1 and `y` = −256 with ACT = 0. With weights = −128, bias = −128, ACT = 0 -> `y` = −512.
- `layer_base` = 254 -> `rom_addr` sequence 254, 255, 0, 1, 2, with `x_idx` 0..3 aligned to the first four addresses.
- `start` held high continuously -> second `start` accepted in the first `y_valid` cycle, results at E6 and E12. `start` pulses while `busy` -> ignored, no extra `y_valid`.
- `rst_n` pulsed low at E3 -> all outputs 0 asynchronously, no `y_valid` pulse. A fresh `start` afterwards yields the correct result at E6 relative to its own start edge.
